// File: rtl/dmux_lane_collector_if.sv
// Handshake bundle between the demux bit stream, the lane collector and the word consumer.
// With DMUX_COLLECT_PARITY_EN defined the bundle also carries word_parity.
interface dmux_lane_collector_if #(
    parameter int WIDTH = 8
);
    logic             a;
    logic             b;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] word;
    logic             word_lane;
    logic             word_valid;
    logic             word_ready;
`ifdef DMUX_COLLECT_PARITY_EN
    logic             word_parity;

    modport master (
        output a, b, sel, in_valid, word_ready,
        input  in_ready, word, word_lane, word_valid, word_parity
    );

    modport slave (
        input  a, b, sel, in_valid, word_ready,
        output in_ready, word, word_lane, word_valid, word_parity
    );
`else
    modport master (
        output a, b, sel, in_valid, word_ready,
        input  in_ready, word, word_lane, word_valid
    );

    modport slave (
        input  a, b, sel, in_valid, word_ready,
        output in_ready, word, word_lane, word_valid
    );
`endif
endinterface

// File: rtl/dmux_lane_collector.sv
// Assembles the two demux lanes into LSB-first words and emits them on one registered port.
// Optional DMUX_COLLECT_PARITY_EN registers word_parity = ^word alongside the word.
module dmux_lane_collector #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    dmux_lane_collector_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift [2];
    logic [CW-1:0]    cnt   [2];
    logic [1:0]       full;
    logic             last_lane;
    logic             accept;
    logic             bit_in;
    logic             out_free;
    logic             load;
    logic             pick;

    // A full lane refuses bits until its word moves into the output register.
    assign bus.in_ready = !full[bus.sel];

    always_comb begin
        accept   = bus.in_valid && !full[bus.sel];
        bit_in   = bus.sel ? bus.b : bus.a;
        out_free = !bus.word_valid || bus.word_ready;
        load     = out_free && (full != 2'b00);
        pick     = (full == 2'b11) ? !last_lane : full[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 2; l++) begin
                shift[l] <= '0;
                cnt[l]   <= '0;
            end
            full <= 2'b00;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (accept && (bus.sel == 1'(l))) begin
                    shift[l][cnt[l]] <= bit_in;
                    if (cnt[l] == LAST_BIT) begin
                        cnt[l]  <= '0;
                        full[l] <= 1'b1;
                    end else begin
                        cnt[l] <= cnt[l] + 1'b1;
                    end
                end
                // accept needs !full and load needs full, so these never collide on one lane
                if (load && (pick == 1'(l))) begin
                    full[l] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.word        <= '0;
            bus.word_lane   <= 1'b0;
            bus.word_valid  <= 1'b0;
            last_lane       <= 1'b1;
`ifdef DMUX_COLLECT_PARITY_EN
            bus.word_parity <= 1'b0;
`endif
        end else if (load) begin
            bus.word        <= shift[pick];
            bus.word_lane   <= pick;
            bus.word_valid  <= 1'b1;
            last_lane       <= pick;
`ifdef DMUX_COLLECT_PARITY_EN
            bus.word_parity <= ^shift[pick];
`endif
        end else if (bus.word_ready) begin
            bus.word_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmux_lane_collector.sv
// Directed bench for dmux_lane_collector: expected words are queued as stimulus is driven
// and popped when the collector hands a word over.
module tb_dmux_lane_collector;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmux_lane_collector_if #(.WIDTH(WIDTH)) bus ();

    dmux_lane_collector #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic             lane;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp  = 0;
    int               n_fail = 0;
    int               stalls = 0;
    logic             hold_v = 1'b0;
    logic [WIDTH:0]   hold_w = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic fail_now(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    endtask

    task automatic expect_word(input logic lane, input logic [WIDTH-1:0] data);
        exp_t e;
        e.lane = lane;
        e.data = data;
        sb.push_back(e);
    endtask

    // Called at the falling edge: a word handshake here completes at the next rising edge.
    task automatic observe();
        exp_t e;
        if (bus.word_valid && bus.word_ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_word", {23'd0, bus.word_lane, bus.word}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("word", 32'(bus.word), 32'(e.data));
                chk("word_lane", 32'(bus.word_lane), 32'(e.lane));
`ifdef DMUX_COLLECT_PARITY_EN
                chk("word_parity", 32'(bus.word_parity), 32'(^e.data));
`endif
            end
        end
        if (bus.word_valid && !bus.word_ready) begin
            if (hold_v) chk("hold_stable", 32'({bus.word_lane, bus.word}), 32'(hold_w));
            hold_v = 1'b1;
            hold_w = {bus.word_lane, bus.word};
        end else begin
            hold_v = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    // The unselected input carries the opposite bit so a wrong mux choice shows up.
    task automatic beat(input logic s, input logic v);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.sel      = s;
        bus.a        = s ? ~v : v;
        bus.b        = s ? v : ~v;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            observe();
            ok = bus.in_ready;
            if (!ok) stalls++;
            @(posedge clk);
            #1;
        end
        if (!ok) fail_now("beat_timeout", 32'(s), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic lane, input logic [WIDTH-1:0] data);
        logic [WIDTH-1:0] d;
        d = data;
        for (int k = 0; k < WIDTH; k++) beat(lane, d[k]);
    endtask

    initial begin
        bus.a          = 1'b0;
        bus.b          = 1'b0;
        bus.sel        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.word_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_word", 32'(bus.word), 32'd0);
        chk("rst_word_lane", 32'(bus.word_lane), 32'd0);
        chk("rst_in_ready_l0", 32'(bus.in_ready), 32'd1);
        bus.sel = 1'b1;
        #1;
        chk("rst_in_ready_l1", 32'(bus.in_ready), 32'd1);
        bus.sel = 1'b0;
`ifdef DMUX_COLLECT_PARITY_EN
        chk("rst_word_parity", 32'(bus.word_parity), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Lane 0 fill, latency and single-cycle valid
        expect_word(1'b0, 8'h4D);
        send_word(1'b0, 8'h4D);
        chk("bubble_in_ready", 32'(bus.in_ready), 32'd0);
        chk("latency_early", 32'(bus.word_valid), 32'd0);
        tick();
        chk("latency_valid", 32'(bus.word_valid), 32'd1);
        tick();
        chk("valid_one_cycle", 32'(bus.word_valid), 32'd0);

        expect_word(1'b0, 8'h07);
        send_word(1'b0, 8'h07);
        repeat (3) tick();
        chk("parity_words_drained", 32'(sb.size()), 32'd0);

        // Interleaved lanes, no stalls expected
        stalls = 0;
        expect_word(1'b0, 8'hFF);
        expect_word(1'b1, 8'h00);
        for (int i = 0; i < 16; i++) beat(1'(i), (i % 2 == 0) ? 1'b1 : 1'b0);
        chk("interleave_no_stall", 32'(stalls), 32'd0);
        repeat (3) tick();
        chk("interleave_drained", 32'(sb.size()), 32'd0);

        // Backpressure on lane 0, lane 1 stays live
        bus.word_ready = 1'b0;
        expect_word(1'b0, 8'h3C);
        expect_word(1'b0, 8'h81);
        send_word(1'b0, 8'h3C);
        send_word(1'b0, 8'h81);
        bus.sel      = 1'b0;
        bus.a        = 1'b1;
        bus.b        = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            observe();
            chk("lane0_blocked", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        stalls = 0;
        repeat (3) beat(1'b1, 1'b1);
        chk("lane1_accepts", 32'(stalls), 32'd0);
        chk("held_word", 32'(bus.word), 32'h3C);
        chk("held_valid", 32'(bus.word_valid), 32'd1);
        bus.word_ready = 1'b1;
        repeat (3) tick();
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-word discards partial bits in both lanes
        repeat (5) beat(1'b0, 1'b1);
        rst = 1'b1;
        #2;
        chk("midrst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        expect_word(1'b0, 8'hA5);
        send_word(1'b0, 8'hA5);
        expect_word(1'b1, 8'h5A);
        send_word(1'b1, 8'h5A);
        repeat (3) tick();
        chk("rst_words_drained", 32'(sb.size()), 32'd0);

        // Round-robin with last_lane=1: lane 0 wins the tie
        bus.word_ready = 1'b0;
        expect_word(1'b1, 8'h44);
        send_word(1'b1, 8'h44);
        send_word(1'b0, 8'h55);
        send_word(1'b1, 8'h66);
        expect_word(1'b0, 8'h55);
        expect_word(1'b1, 8'h66);
        bus.word_ready = 1'b1;
        repeat (3) tick();
        chk("rr_a_back_to_back", 32'(sb.size()), 32'd0);

        // Round-robin with last_lane=0: lane 1 wins the tie
        bus.word_ready = 1'b0;
        expect_word(1'b0, 8'h11);
        send_word(1'b0, 8'h11);
        send_word(1'b0, 8'h22);
        send_word(1'b1, 8'h33);
        expect_word(1'b1, 8'h33);
        expect_word(1'b0, 8'h22);
        bus.word_ready = 1'b1;
        repeat (3) tick();
        chk("rr_b_back_to_back", 32'(sb.size()), 32'd0);

        repeat (4) tick();
        chk("final_empty", 32'(sb.size()), 32'd0);
        chk("final_idle", 32'(bus.word_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
